// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, issues word reads to main memory, waits for ACK
// (or a bounded timeout), and hands the captured word to the decoder over a
// valid/ready handshake. Stops for good after delivering the halt word.
//
// state  | meaning
// IDLE   | one cycle after reset before the first request
// REQ    | read strobe out at ADDRESS=pc, waiting for ACK or timeout
// HOLD   | IR/PC_Out valid to decoder, waiting for READY
// HALTED | halt word delivered; only reset leaves this state
module instruction_fetch_unit #(
  parameter int unsigned              DATAWIDTH_BUS = 32,
  parameter logic [DATAWIDTH_BUS-1:0] RESET_PC      = '0,
  parameter int unsigned              ACK_TIMEOUT   = 4,
  parameter logic [DATAWIDTH_BUS-1:0] HALT_WORD     = '1
) (
  input  logic                     FETCH_CLOCK_50,
  input  logic                     FETCH_RESET_InLow,
  output logic [DATAWIDTH_BUS-1:0] FETCH_MEM_ADDRESS_OutBUS,
  output logic                     FETCH_MEM_RD_Out,
  output logic                     FETCH_MEM_WR_Out,
  input  logic [DATAWIDTH_BUS-1:0] FETCH_MEM_data_InBUS,
  input  logic                     FETCH_MEM_ACK_In,
  output logic [DATAWIDTH_BUS-1:0] FETCH_IR_OutBUS,
  output logic [DATAWIDTH_BUS-1:0] FETCH_PC_OutBUS,
  output logic                     FETCH_VALID_Out,
  input  logic                     FETCH_READY_In,
  input  logic                     FETCH_REDIRECT_In,
  input  logic [DATAWIDTH_BUS-1:0] FETCH_REDIRECT_TARGET_InBUS,
  output logic                     FETCH_HALT_Out,
  output logic                     FETCH_TIMEOUT_Out
);

  localparam int unsigned CW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, REQ, HOLD, HALTED} state_t;

  state_t                   state;
  logic [DATAWIDTH_BUS-1:0] pc;
  logic [CW-1:0]            wait_cnt;
  logic                     halt_pending;
  // First REQ cycle after a redirect keeps RD low so the new address is
  // presented cleanly; no capture can happen in that cycle.
  logic                     bubble;
  logic                     capture;

  // Memory is never written from the fetch stage.
  assign FETCH_MEM_WR_Out = 1'b0;

  // Capture on ACK, or on the last permitted REQ cycle without one.
  always_comb begin
    capture = 1'b0;
    if (state == REQ && !bubble)
      capture = FETCH_MEM_ACK_In || (wait_cnt == CNT_LAST);
  end

  // Fetch sequencer: PC, request strobe, instruction register and flags.
  always_ff @(posedge FETCH_CLOCK_50) begin
    if (!FETCH_RESET_InLow) begin
      state                    <= IDLE;
      pc                       <= RESET_PC;
      wait_cnt                 <= '0;
      halt_pending             <= 1'b0;
      bubble                   <= 1'b0;
      FETCH_MEM_RD_Out         <= 1'b0;
      FETCH_MEM_ADDRESS_OutBUS <= '0;
      FETCH_IR_OutBUS          <= '0;
      FETCH_PC_OutBUS          <= '0;
      FETCH_VALID_Out          <= 1'b0;
      FETCH_HALT_Out           <= 1'b0;
      FETCH_TIMEOUT_Out        <= 1'b0;
    end else if (FETCH_REDIRECT_In && state != HALTED) begin
      // Redirect discards whatever is in flight or held.
      state            <= REQ;
      pc               <= FETCH_REDIRECT_TARGET_InBUS;
      wait_cnt         <= '0;
      halt_pending     <= 1'b0;
      bubble           <= 1'b1;
      FETCH_MEM_RD_Out <= 1'b0;
      FETCH_VALID_Out  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state                    <= REQ;
          bubble                   <= 1'b0;
          FETCH_MEM_RD_Out         <= 1'b1;
          FETCH_MEM_ADDRESS_OutBUS <= pc;
        end
        REQ: begin
          if (bubble) begin
            bubble                   <= 1'b0;
            FETCH_MEM_RD_Out         <= 1'b1;
            FETCH_MEM_ADDRESS_OutBUS <= pc;
          end else if (capture) begin
            state            <= HOLD;
            FETCH_IR_OutBUS  <= FETCH_MEM_data_InBUS;
            FETCH_PC_OutBUS  <= pc;
            pc               <= pc + 1'b1;
            FETCH_VALID_Out  <= 1'b1;
            FETCH_MEM_RD_Out <= 1'b0;
            wait_cnt         <= '0;
            if (!FETCH_MEM_ACK_In)
              FETCH_TIMEOUT_Out <= 1'b1;
            if (FETCH_MEM_data_InBUS == HALT_WORD)
              halt_pending <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        HOLD: begin
          if (FETCH_VALID_Out && FETCH_READY_In) begin
            FETCH_VALID_Out <= 1'b0;
            if (halt_pending) begin
              state          <= HALTED;
              FETCH_HALT_Out <= 1'b1;
            end else begin
              state                    <= REQ;
              FETCH_MEM_RD_Out         <= 1'b1;
              FETCH_MEM_ADDRESS_OutBUS <= pc;
            end
          end
        end
        HALTED: begin
          FETCH_MEM_RD_Out <= 1'b0;
          FETCH_VALID_Out  <= 1'b0;
          FETCH_HALT_Out   <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
